// File: rtl/rx_lane_sync_ctrl_if.sv
// Lane data bus between the serial-to-parallel converters, the lane sync controller and the RX demux.
// The master modport is the side that drives lane bytes in and observes the gated result.
interface rx_lane_sync_ctrl_if;
  logic [31:0] data_in;
  logic [3:0]  valid_in;
  logic [31:0] data_out;
  logic [3:0]  valid_out;
  logic [3:0]  sync_out;
  logic        active_out;

  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  valid_out,
    input  sync_out,
    input  active_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output valid_out,
    output sync_out,
    output active_out
  );
endinterface

// File: rtl/rx_lane_sync_ctrl.sv
// Four-lane COM-based sync controller: one LOSS/SYNCED FSM per lane, and payload gating so the
// demux only sees non-COM, non-IDL bytes while every lane is synchronized.
module rx_lane_sync_ctrl #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter logic [7:0] IDL        = 8'h7C,
  parameter logic [3:0] SYNC_COUNT = 4'd4,
  parameter logic [3:0] LOSS_COUNT = 4'd4
) (
  input  logic                 clk_f,
  input  logic                 reset_L,
  rx_lane_sync_ctrl_if.slave   bus
);

  typedef enum logic {
    LOSS   = 1'b0,
    SYNCED = 1'b1
  } lane_state_t;

  lane_state_t [3:0] state_q, state_d;
  logic [3:0][3:0]   com_cnt_q, com_cnt_d;
  logic [3:0][3:0]   miss_cnt_q, miss_cnt_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        valid_q, valid_d;
  logic [3:0]        sync;
  logic              active;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sync[i] = (state_q[i] == SYNCED);
    end
  end

  assign active = &sync;

  // Lane FSMs and output gating; gating uses the pre-edge active flag, so a lane that
  // completes acquisition or drops out this cycle only affects the following edge.
  always_comb begin
    state_d    = state_q;
    com_cnt_d  = com_cnt_q;
    miss_cnt_d = miss_cnt_q;
    data_d     = data_q;
    valid_d    = '0;
    for (int i = 0; i < 4; i++) begin
      case (state_q[i])
        LOSS: begin
          miss_cnt_d[i] = '0;
          if (bus.valid_in[i] && (bus.data_in[8*i +: 8] == COM)) begin
            if (sat_inc(com_cnt_q[i]) == SYNC_COUNT) begin
              state_d[i]   = SYNCED;
              com_cnt_d[i] = '0;
            end else begin
              com_cnt_d[i] = sat_inc(com_cnt_q[i]);
            end
          end else begin
            com_cnt_d[i] = '0;
          end
        end
        SYNCED: begin
          com_cnt_d[i] = '0;
          if (!bus.valid_in[i]) begin
            if (sat_inc(miss_cnt_q[i]) == LOSS_COUNT) begin
              state_d[i]    = LOSS;
              miss_cnt_d[i] = '0;
            end else begin
              miss_cnt_d[i] = sat_inc(miss_cnt_q[i]);
            end
          end else begin
            miss_cnt_d[i] = '0;
          end
        end
        default: begin
          state_d[i]    = LOSS;
          com_cnt_d[i]  = '0;
          miss_cnt_d[i] = '0;
        end
      endcase

      if (active && bus.valid_in[i] &&
          (bus.data_in[8*i +: 8] != COM) && (bus.data_in[8*i +: 8] != IDL)) begin
        valid_d[i]        = 1'b1;
        data_d[8*i +: 8]  = bus.data_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= {4{LOSS}};
      com_cnt_q  <= '0;
      miss_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      com_cnt_q  <= com_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.sync_out   = sync;
  assign bus.active_out = active;

endmodule

// File: tb/tb_rx_lane_sync_ctrl.sv
// Directed bench for rx_lane_sync_ctrl: acquisition, stripping, loss, async reset and broken COM runs.
module tb_rx_lane_sync_ctrl;

  logic clk_f;
  logic reset_L;
  int   checks_total;
  int   checks_passed;

  rx_lane_sync_ctrl_if bus ();

  rx_lane_sync_ctrl dut (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one byte-clock of lane data, then look at the outputs just after the edge.
  task automatic apply_stimulus(input logic [31:0] data, input logic [3:0] valid);
    @(negedge clk_f);
    bus.data_in  = data;
    bus.valid_in = valid;
    @(posedge clk_f);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] sync, input logic active, input logic [3:0] valid);
    check_output({tag, ".sync"},   {28'd0, bus.sync_out},   {28'd0, sync});
    check_output({tag, ".active"}, {31'd0, bus.active_out}, {31'd0, active});
    check_output({tag, ".valid"},  {28'd0, bus.valid_out},  {28'd0, valid});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", checks_passed, checks_total + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset_L       = 1'b0;
    bus.data_in   = '0;
    bus.valid_in  = '0;

    // Reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_f);
      bus.data_in  = $urandom;
      bus.valid_in = 4'($urandom);
    end
    #1;
    check_all("rst", 4'h0, 1'b0, 4'h0);
    check_output("rst.data", bus.data_out, 32'h0);
    @(negedge clk_f);
    reset_L = 1'b1;

    apply_stimulus(32'h0000_0000, 4'hF);
    apply_stimulus(32'h0000_0000, 4'hF);
    check_all("idle0", 4'h0, 1'b0, 4'h0);
    check_output("idle0.data", bus.data_out, 32'h0);

    // Acquisition on all lanes
    for (int k = 0; k < 3; k++) apply_stimulus(32'hBCBC_BCBC, 4'hF);
    check_all("acq3", 4'h0, 1'b0, 4'h0);
    apply_stimulus(32'hBCBC_BCBC, 4'hF);
    check_all("acq4", 4'hF, 1'b1, 4'h0);
    apply_stimulus(32'hA5A5_A5A5, 4'hF);
    check_all("pay1", 4'hF, 1'b1, 4'hF);
    check_output("pay1.data", bus.data_out, 32'hA5A5_A5A5);

    // Lane 2 silent for 3 cycles: stays synced, other lanes keep delivering
    for (int k = 0; k < 3; k++) apply_stimulus(32'h1234_5678, 4'hB);
    check_all("miss3", 4'hF, 1'b1, 4'hB);
    check_output("miss3.data", bus.data_out, 32'h12A5_5678);
    apply_stimulus(32'hA5A5_A5A5, 4'hF);
    check_all("miss3r", 4'hF, 1'b1, 4'hF);

    // Lane 2 silent for 4 cycles: loses sync on the 4th edge
    for (int k = 0; k < 3; k++) apply_stimulus(32'hA5A5_A5A5, 4'hB);
    check_all("loss3", 4'hF, 1'b1, 4'hB);
    apply_stimulus(32'hA5A5_A5A5, 4'hB);
    check_all("loss4", 4'hB, 1'b0, 4'hB);
    apply_stimulus(32'h1111_1111, 4'hF);
    check_all("loss5", 4'hB, 1'b0, 4'h0);
    check_output("loss5.data", bus.data_out, 32'hA5A5_A5A5);

    // Lane 2 re-acquires with four COMs
    for (int k = 0; k < 3; k++) apply_stimulus(32'hBCBC_BCBC, 4'hF);
    check_all("reacq3", 4'hB, 1'b0, 4'h0);
    apply_stimulus(32'hBCBC_BCBC, 4'hF);
    check_all("reacq4", 4'hF, 1'b1, 4'h0);

    // Lane 0 strips IDL and COM, forwards 3C
    apply_stimulus(32'h5555_557C, 4'hF);
    check_all("strip_idl", 4'hF, 1'b1, 4'hE);
    check_output("strip_idl.data", bus.data_out, 32'h5555_55A5);
    apply_stimulus(32'h5555_55BC, 4'hF);
    check_all("strip_com", 4'hF, 1'b1, 4'hE);
    apply_stimulus(32'h5555_553C, 4'hF);
    check_all("strip_pay", 4'hF, 1'b1, 4'hF);
    check_output("strip_pay.data", bus.data_out, 32'h5555_553C);

    // Asynchronous reset in the middle of a payload stream
    apply_stimulus(32'h1234_5678, 4'hF);
    check_output("mid.valid", {28'd0, bus.valid_out}, 32'hF);
    @(negedge clk_f);
    #2;
    reset_L = 1'b0;
    #1;
    check_all("async_rst", 4'h0, 1'b0, 4'h0);
    check_output("async_rst.data", bus.data_out, 32'h0);
    @(negedge clk_f);
    reset_L = 1'b1;

    // Broken COM run on lane 1 after reset; other lanes move on to payload bytes
    apply_stimulus(32'hBCBC_BCBC, 4'hF);
    apply_stimulus(32'hBCBC_BCBC, 4'hF);
    apply_stimulus(32'hBCBC_BCBC, 4'hF);
    check_all("brk3", 4'h0, 1'b0, 4'h0);
    apply_stimulus(32'hBCBC_00BC, 4'hF);
    check_all("brk4", 4'hD, 1'b0, 4'h0);
    for (int k = 0; k < 3; k++) apply_stimulus(32'h7777_BC77, 4'hF);
    check_all("brk7", 4'hD, 1'b0, 4'h0);
    check_output("brk7.data", bus.data_out, 32'h0);
    apply_stimulus(32'h7777_BC77, 4'hF);
    check_all("brk8", 4'hF, 1'b1, 4'h0);
    apply_stimulus(32'h9999_9999, 4'hF);
    check_all("brk9", 4'hF, 1'b1, 4'hF);
    check_output("brk9.data", bus.data_out, 32'h9999_9999);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/rx_lane_sync_ctrl.md
Name: rx_lane_sync_ctrl

Overview:
Receive-side lane synchronization controller for the 4-lane PHY RX path. It sits between the per-lane serial-to-parallel converters and the RX demux stage. It runs one COM-based sync state machine per lane and gates lane data and valid so that the demux only sees payload bytes. Payload is released only once every lane is synchronized.

Parameters:
COM, 8'hBC, comma/alignment symbol
IDL, 8'h7C, idle symbol (stripped, never forwarded)
SYNC_COUNT, 4, consecutive valid COM bytes required to acquire sync on a lane (legal range 1..15)
LOSS_COUNT, 4, consecutive cycles with valid_in low that drop sync on a lane (legal range 1..15)

Ports:
clk_f  input  1  byte clock, all logic on posedge
reset_L  input  1  asynchronous active-low reset
data_in  input  32  lane i byte = data_in[8i+7:8i], i=0..3
valid_in  input  4  per-lane byte-valid from serial-to-parallel
data_out  output  32  gated lane bytes to demux, same packing as data_in
valid_out  output  4  per-lane payload valid to demux
sync_out  output  4  per-lane synced flag (FSM in SYNCED)
active_out  output  1  all lanes synced

Behaviour:
- Reset: reset_L low asynchronously forces every lane FSM to LOSS, clears all counters, and drives data_out=0, valid_out=0, sync_out=0, active_out=0. All outputs are registered except active_out, which is the AND of the registered sync_out bits.
- Per-lane FSM, two states; sync_out[i]=1 only in SYNCED.
  - LOSS: 4-bit saturating counter com_cnt.
    - valid_in[i]=1 and byte==COM: com_cnt++.
    - Any other cycle, including valid_in low or a non-COM byte: com_cnt<=0.
    - When the increment reaches SYNC_COUNT, go to SYNCED at that edge and clear com_cnt.
  - SYNCED: 4-bit saturating counter miss_cnt.
    - valid_in[i]=0: miss_cnt++.
    - valid_in[i]=1: miss_cnt<=0.
    - When the increment reaches LOSS_COUNT, go to LOSS and clear miss_cnt.
    - COM bytes received while SYNCED keep the lane synced and are not errors.
- Lanes are independent. There is no inter-lane deskew.
- Output gating is evaluated on pre-edge (current) state. At each posedge:
  - valid_out[i] <= active_out & valid_in[i] & (byte != COM) & (byte != IDL).
  - data_out lane i <= byte when that condition holds, otherwise holds its previous value.
  - Latency is 1 clk_f from data_in to data_out/valid_out.
- The byte that completes acquisition is a COM, so it is never forwarded. The first possible payload is the byte sampled on the edge after active_out rises, appearing one cycle later.
- Loss on any lane drops active_out in the cycle after that lane's transition edge. From the next edge, valid_out is 0 on all lanes. Bytes on still-synced lanes are dropped, not buffered.
- Simultaneous events:
  - A lane reaching SYNC_COUNT on the same edge another lane reaches LOSS_COUNT: active_out stays 0.
  - A lane with valid_in low while another lane delivers payload: only the delivering lane asserts valid_out. The silent lane's miss_cnt advances.
- Reset mid-operation: reset asserts immediately and asynchronously. After release, acquisition restarts from com_cnt=0 on all lanes.
- Counters saturate at 15 and never wrap.

Test Plan:
- Reset: hold reset_L=0 with random inputs -> data_out=0, valid_out=0, sync_out=0, active_out=0. Release, then drive valid_in=4'hF with 8'h00 -> outputs stay 0.
- Acquisition: 4 cycles of COM on all lanes, then 8'hA5 on all lanes -> sync_out=4'hF and active_out=1 after the 4th edge. valid_out=4'hF with data_out=32'hA5A5A5A5 one cycle after A5 is sampled.
- Broken run: lane 1 sends COM,COM,COM,8'h00,COM×4 while other lanes send COM×4 -> sync_out=4'b1101 until lane 1's 4th consecutive COM. active_out stays 0 and valid_out stays 0 throughout.
- Stripping: synced link, lane 0 sends IDL, COM, 8'h3C with valid_in high -> valid_out[0] is 0, 0, then 1 with data_out[7:0]=8'h3C. Lane 0 stays synced.
- Loss: synced link, valid_in[2]=0 for 3 cycles then 1 -> stays synced. valid_in[2]=0 for 4 cycles -> sync_out[2]=0, active_out=0, all valid_out=0 on following edges; re-acquisition needs 4 COMs on lane 2.
- Reset mid-payload: assert reset_L=0 asynchronously mid-cycle during a payload stream -> all outputs 0 immediately, without a clock edge. After release, no valid_out until a full re-acquisition.
